// File: rtl/data_port_arbiter.sv
// Round-robin arbiter sharing the data-memory port between the core load/store
// unit (m0) and the monitor bridge (m1); each access is IDLE -> ACCESS -> RESP.
module data_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          prg_mode,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wd,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rd,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wd,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   rr_q, rr_d;
  logic   elig0, elig1;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wd;

  assign elig0 = m0_req & ~prg_mode;
  assign elig1 = m1_req;

  assign sel_we   = owner_q ? m1_we   : m0_we;
  assign sel_addr = owner_q ? m1_addr : m0_addr;
  assign sel_wd   = owner_q ? m1_wd   : m0_wd;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          // Lone eligible master wins outright; a tie goes to the rr pointer.
          owner_d = (elig0 & elig1) ? rr_q : elig1;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        rr_d    = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_rd    = '0;
    m1_rd    = '0;
    case (state_q)
      ACCESS: begin
        mem_we   = sel_we;
        mem_addr = sel_addr;
        mem_wd   = sel_wd;
      end
      RESP: begin
        mem_addr = sel_addr;
        m0_ack   = ~owner_q;
        m1_ack   = owner_q;
        m0_rd    = owner_q ? '0 : mem_rd;
        m1_rd    = owner_q ? mem_rd : '0;
      end
      default: ;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_data_port_arbiter.sv
// Directed bench for data_port_arbiter with a registered-read memory model.
module tb_data_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n, prg_mode;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rd, m1_rd;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd;
  logic [31:0] mem_rd = '0;
  logic        busy, owner;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] store [0:63];

  always #5 clk = ~clk;

  data_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset_n(reset_n), .prg_mode(prg_mode),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_ack(m0_ack), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_ack(m1_ack), .m1_rd(m1_rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy), .owner(owner)
  );

  // Registered memory: address 0x10 is a fixed 0xDEADBEEF location.
  always @(posedge clk) begin
    if (mem_we) store[mem_addr[7:2]] <= mem_wd;
    mem_rd <= (mem_addr == 32'h10) ? 32'hDEAD_BEEF : store[mem_addr[7:2]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; prg_mode = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wd = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wd = '0;
    step(); step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (owner !== 1'b0) begin n_bad++; $display("FAIL reset_owner got %0b want 0", owner); end
    n_cmp++; if ({m0_ack, m1_ack, mem_we} !== 3'b000) begin n_bad++; $display("FAIL reset_acks_we got %03b want 000", {m0_ack, m1_ack, mem_we}); end
    n_cmp++; if ({mem_addr, mem_wd} !== 64'h0) begin n_bad++; $display("FAIL reset_mem got %h/%h want 0/0", mem_addr, mem_wd); end
    n_cmp++; if ({m0_rd, m1_rd} !== 64'h0) begin n_bad++; $display("FAIL reset_rd got %h/%h want 0/0", m0_rd, m1_rd); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    m1_req = 1; m1_we = 0; m1_addr = 32'h10;
    step();
    n_cmp++; if ({busy, owner, mem_we, m1_ack} !== 4'b1100) begin n_bad++; $display("FAIL read_access busy/owner/we/ack got %04b want 1100", {busy, owner, mem_we, m1_ack}); end
    n_cmp++; if (mem_addr !== 32'h10) begin n_bad++; $display("FAIL read_access_addr got %h want 00000010", mem_addr); end
    step();
    n_cmp++; if ({m1_ack, m0_ack, mem_we} !== 3'b100) begin n_bad++; $display("FAIL read_resp ack1/ack0/we got %03b want 100", {m1_ack, m0_ack, mem_we}); end
    n_cmp++; if (m1_rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL read_resp_rd got %h want deadbeef", m1_rd); end
    n_cmp++; if (m0_rd !== 32'h0) begin n_bad++; $display("FAIL read_resp_m0rd got %h want 0", m0_rd); end
    m1_req = 0;
    step();
    n_cmp++; if ({busy, m1_ack, m1_rd} !== 34'h0) begin n_bad++; $display("FAIL read_after busy/ack/rd got %0b/%0b/%h want 0/0/0", busy, m1_ack, m1_rd); end
  endtask

  task automatic test_single_write();
    m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wd = 32'h1234_5678;
    step();
    n_cmp++; if ({mem_we, owner, m0_ack} !== 3'b100) begin n_bad++; $display("FAIL write_access we/owner/ack got %03b want 100", {mem_we, owner, m0_ack}); end
    n_cmp++; if ({mem_addr, mem_wd} !== {32'h20, 32'h1234_5678}) begin n_bad++; $display("FAIL write_access addr/wd got %h/%h want 00000020/12345678", mem_addr, mem_wd); end
    step();
    n_cmp++; if ({mem_we, m0_ack, m1_ack} !== 3'b010) begin n_bad++; $display("FAIL write_resp we/ack0/ack1 got %03b want 010", {mem_we, m0_ack, m1_ack}); end
    n_cmp++; if (mem_addr !== 32'h20) begin n_bad++; $display("FAIL write_resp_addr got %h want 00000020", mem_addr); end
    m0_req = 0; m0_we = 0;
    step();
    n_cmp++; if ({mem_we, m0_ack, busy} !== 3'b000) begin n_bad++; $display("FAIL write_after we/ack/busy got %03b want 000", {mem_we, m0_ack, busy}); end
  endtask

  task automatic test_contention();
    reset_n = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_addr = 32'h20;
    step();
    reset_n = 1;
    for (int c = 1; c <= 12; c++) begin
      logic e0, e1;
      step();
      e0 = (c == 2) || (c == 8);
      e1 = (c == 5) || (c == 11);
      n_cmp++; if ({m0_ack, m1_ack} !== {e0, e1}) begin n_bad++; $display("FAIL contend_acks cycle %0d got %b%b want %b%b", c, m0_ack, m1_ack, e0, e1); end
      if (e0) begin
        n_cmp++; if (m0_rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL contend_m0rd cycle %0d got %h want deadbeef", c, m0_rd); end
      end
      if (e1) begin
        n_cmp++; if (m1_rd !== 32'h1234_5678) begin n_bad++; $display("FAIL contend_m1rd cycle %0d got %h want 12345678", c, m1_rd); end
      end
    end
    m0_req = 0; m1_req = 0;
    step();
  endtask

  task automatic test_prg_mode();
    prg_mode = 1; m0_req = 1; m1_req = 1;
    for (int c = 1; c <= 15; c++) begin
      logic e0, e1;
      step();
      e0 = (c == 11);
      e1 = (c == 2) || (c == 5) || (c == 8) || (c == 14);
      n_cmp++; if ({m0_ack, m1_ack} !== {e0, e1}) begin n_bad++; $display("FAIL prg_acks cycle %0d got %b%b want %b%b", c, m0_ack, m1_ack, e0, e1); end
      if (c == 9) prg_mode = 0;
    end
    m0_req = 0; m1_req = 0;
    step();
  endtask

  task automatic test_mode_change();
    prg_mode = 0; m0_req = 1; m1_req = 1;
    step();
    n_cmp++; if ({busy, owner} !== 2'b10) begin n_bad++; $display("FAIL modechg_grant busy/owner got %b%b want 10", busy, owner); end
    prg_mode = 1;
    step();
    n_cmp++; if ({m0_ack, m1_ack} !== 2'b10) begin n_bad++; $display("FAIL modechg_ack got %b%b want 10", m0_ack, m1_ack); end
    step(); step();
    n_cmp++; if ({busy, owner} !== 2'b11) begin n_bad++; $display("FAIL modechg_next busy/owner got %b%b want 11", busy, owner); end
    m0_req = 0; m1_req = 0;
    step();
    n_cmp++; if ({m0_ack, m1_ack} !== 2'b01) begin n_bad++; $display("FAIL modechg_ack1 got %b%b want 01", m0_ack, m1_ack); end
    prg_mode = 0;
    step();
  endtask

  task automatic test_reset_mid();
    // Complete an m0 access so the pointer points at m1 before the abort.
    m0_req = 1; m0_addr = 32'h10;
    step(); step();
    m0_req = 0;
    step();
    m0_req = 1;
    step(); step();
    n_cmp++; if ({busy, m0_ack} !== 2'b11) begin n_bad++; $display("FAIL rstmid_resp busy/ack got %b%b want 11", busy, m0_ack); end
    reset_n = 0;
    step();
    n_cmp++; if ({busy, owner, m0_ack, m1_ack, mem_we} !== 5'b0) begin n_bad++; $display("FAIL rstmid_ctrl got %05b want 00000", {busy, owner, m0_ack, m1_ack, mem_we}); end
    n_cmp++; if ({mem_addr, mem_wd, m0_rd, m1_rd} !== 128'h0) begin n_bad++; $display("FAIL rstmid_data got %h/%h/%h/%h want 0", mem_addr, mem_wd, m0_rd, m1_rd); end
    m0_req = 0;
    reset_n = 1;
    step();
    n_cmp++; if ({m0_ack, busy} !== 2'b00) begin n_bad++; $display("FAIL rstmid_noack got %b%b want 00", m0_ack, busy); end
    m0_req = 1; m1_req = 1;
    step();
    n_cmp++; if ({busy, owner} !== 2'b10) begin n_bad++; $display("FAIL rstmid_rr busy/owner got %b%b want 10", busy, owner); end
    m0_req = 0; m1_req = 0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_prg_mode();
    test_mode_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
